// File: rtl/arp_pkg.sv
// Shared types and constants for the arpeggio sequencer.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none.
package arp_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ARP  = 2'd2
    } arp_state_t;

    // Index into the four-note arpeggio
    typedef logic [1:0] note_t;

    localparam int    PERIOD_W   = 10;
    localparam int    SAMPLE_W   = 11;
    localparam int    PROD_W     = 16;
    localparam note_t NOTE_FIRST = 2'd0;
    localparam note_t NOTE_LAST  = 2'd3;

    // Note ratios relative to the base period, as multiply-then-shift pairs
    localparam logic [PROD_W-1:0] NOTE1_MUL  = 16'd51;
    localparam logic [PROD_W-1:0] NOTE2_MUL  = 16'd43;
    localparam int                NOTE_SHIFT = 6;

    // Sample period for a note, derived from the base period.
    // The product is kept in 16 bits and the result truncated to the period width.
    function automatic logic [PERIOD_W-1:0] note_period(input logic [PERIOD_W-1:0] p0,
                                                        input note_t             n);
        logic [PROD_W-1:0] wide;
        logic [PROD_W-1:0] scaled;
        wide   = {{(PROD_W-PERIOD_W){1'b0}}, p0};
        scaled = wide;
        case (n)
            2'd1:    scaled = (wide * NOTE1_MUL) >> NOTE_SHIFT;
            2'd2:    scaled = (wide * NOTE2_MUL) >> NOTE_SHIFT;
            2'd3:    scaled = wide >> 1;
            default: scaled = wide;
        endcase
        return PERIOD_W'(scaled);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: picks the current note's period and emits one tick per period.
// Latency: tick is combinational from the count register; it fires on the last count of a period.
// Backpressure: none; the divider free-runs while run_i is high and is cleared while it is low.
module sample_tick_gen
    import arp_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                run_i,
    input  logic [PERIOD_W-1:0] p0_i,
    input  note_t               note_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_last;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                tick;

    // Current period follows the note and base period; both only change while the count is 0
    always_comb begin
        period      = note_period(p0_i, note_i);
        period_last = period - PERIOD_W'(1);
    end

    // The >= makes the divider self-recover if the period ever shrinks below the count
    assign tick   = run_i && (cnt_q >= period_last);
    assign tick_o = tick;

    // Next count: 0..period-1, restart on tick, parked at 0 while stopped
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Divider count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arp_sequencer.sv
// Wavetable arpeggiator: steps a BRAM address at the note's sample rate and cycles notes on table wraps.
// Latency: pwm_sample/sample_valid update one cycle after the divider tick; note changes land on the wrap tick.
// Backpressure: none; the BRAM is read-only with fixed one-cycle latency. Optional ARP_UPDOWN_EN gives 0,1,2,3,2,1 order.
module arp_sequencer
    import arp_pkg::*;
#(
    parameter int DIV_BASE   = 746,
    parameter int NOTE_DWELL = 25_000_000,
    parameter int ADDR_W     = 8
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              arp_en,
    input  logic [7:0]        sw_base,
    input  logic [10:0]       douta,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    output logic [10:0]       pwm_sample,
    output logic              sample_valid,
    output logic [1:0]        note
);

    localparam logic [PERIOD_W-1:0] P0_RESET   = PERIOD_W'(DIV_BASE);
    localparam logic [31:0]         DWELL_LAST = 32'(NOTE_DWELL - 1);
    localparam logic [ADDR_W-1:0]   ADDR_LAST  = '1;

    arp_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    note_t               note_q, note_d;
    logic [PERIOD_W-1:0] p0_q, p0_d;
    logic [31:0]         dwell_q, dwell_d;
    logic                pending_q, pending_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
`ifdef ARP_UPDOWN_EN
    logic                dir_down_q, dir_down_d;
    logic                step_dir_down;
`endif

    logic                run;
    logic                tick;
    logic                wrap;
    logic                dwell_expire;
    logic                step_now;
    logic [PERIOD_W-1:0] p0_sw;
    note_t               step_note;

    assign run          = (state_q != ST_IDLE);
    assign wrap         = tick && (addr_q == ADDR_LAST);
    assign dwell_expire = (state_q == ST_ARP) && (dwell_q == DWELL_LAST);
    // A step is owed either from an earlier expiry or from one landing on this very wrap
    assign step_now     = wrap && (state_q == ST_ARP) && (pending_q || dwell_expire);
    assign p0_sw        = P0_RESET + PERIOD_W'(sw_base);

    sample_tick_gen u_tick (
        .clk    (CLK100MHZ),
        .reset  (reset),
        .run_i  (run),
        .p0_i   (p0_q),
        .note_i (note_q),
        .tick_o (tick)
    );

    // FSM state register
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE lasts one cycle after reset, then arp_en selects HOLD or ARP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_HOLD;
            ST_HOLD: if (arp_en) state_d = ST_ARP;
            ST_ARP:  if (!arp_en) state_d = ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ARP_UPDOWN_EN
    // Next note when bouncing: turn around at note 3 and at note 0
    always_comb begin
        step_note     = note_q + 2'd1;
        step_dir_down = dir_down_q;
        if (!dir_down_q) begin
            if (note_q == NOTE_LAST) begin
                step_note     = note_q - 2'd1;
                step_dir_down = 1'b1;
            end
        end else begin
            if (note_q == NOTE_FIRST) begin
                step_note     = note_q + 2'd1;
                step_dir_down = 1'b0;
            end else begin
                step_note     = note_q - 2'd1;
            end
        end
    end
`else
    // Next note in plain ascending order, 3 rolls over to 0
    always_comb begin
        step_note = note_q + 2'd1;
    end
`endif

    // Datapath next state: address/sample on tick, base period and note on wrap, dwell timing in ARP
    always_comb begin
        addr_d    = addr_q;
        note_d    = note_q;
        p0_d      = p0_q;
        dwell_d   = dwell_q;
        pending_d = pending_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
`ifdef ARP_UPDOWN_EN
        dir_down_d = dir_down_q;
`endif

        // IDLE always exits on the next edge, so this is the leaving-IDLE capture
        if (state_q == ST_IDLE) begin
            p0_d = p0_sw;
        end

        // douta still holds the word for the current address, which has been stable for the whole period
        if (tick) begin
            addr_d   = addr_q + ADDR_W'(1);
            sample_d = douta;
            valid_d  = 1'b1;
        end

        if (state_q == ST_ARP) begin
            if (dwell_expire) begin
                dwell_d = '0;
                // An expiry on the wrap itself is consumed immediately rather than queued
                if (!wrap) begin
                    pending_d = 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 32'd1;
            end
        end else begin
            dwell_d = '0;
        end

        // Pitch only changes between table passes so a waveform cycle is never split
        if (wrap) begin
            p0_d      = p0_sw;
            pending_d = 1'b0;
            if (state_q == ST_HOLD) begin
                note_d = NOTE_FIRST;
`ifdef ARP_UPDOWN_EN
                dir_down_d = 1'b0;
`endif
            end else if (step_now) begin
                note_d = step_note;
`ifdef ARP_UPDOWN_EN
                dir_down_d = step_dir_down;
`endif
            end
        end
    end

    // Datapath registers; reset wins over any tick in the same edge
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            addr_q    <= '0;
            note_q    <= NOTE_FIRST;
            p0_q      <= P0_RESET;
            dwell_q   <= '0;
            pending_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
`ifdef ARP_UPDOWN_EN
            dir_down_q <= 1'b0;
`endif
        end else begin
            addr_q    <= addr_d;
            note_q    <= note_d;
            p0_q      <= p0_d;
            dwell_q   <= dwell_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
`ifdef ARP_UPDOWN_EN
            dir_down_q <= dir_down_d;
`endif
        end
    end

    assign ena          = run;
    assign addra        = addr_q;
    assign pwm_sample   = sample_q;
    assign sample_valid = valid_q;
    assign note         = note_q;

endmodule

// File: doc/arp_sequencer.md
ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 Parameter DIV_BASE, default 746, base sample-period offset in clock cycles.
REQ-002 Parameter NOTE_DWELL, default 25_000_000, clock cycles a note is held before an arpeggio step is requested.
REQ-003 Parameter ADDR_W, default 8, waveform table address width (table depth 2**ADDR_W).
REQ-004 CLK100MHZ  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 arp_en  input  1  debounced level; 1 = arpeggiate, 0 = hold base note.
REQ-007 sw_base  input  8  base-frequency trim, added to DIV_BASE.
REQ-008 douta  input  11  waveform sample from block RAM, valid 1 cycle after addra changes.
REQ-009 ena  output  1  block RAM enable.
REQ-010 addra  output  ADDR_W  block RAM read address.
REQ-011 pwm_sample  output  11  sample to PWM modulator, held between updates.
REQ-012 sample_valid  output  1  one-cycle pulse when pwm_sample updates.
REQ-013 note  output  2  current note index, for LEDs.

Function
REQ-014 Base period P0 = DIV_BASE + sw_base (10 bits), sampled only at table wrap (addra ADDR_W'max -> 0) or on leaving IDLE.
REQ-015 Note periods (16-bit intermediate, truncate): note0 = P0, note1 = (P0*51)>>6, note2 = (P0*43)>>6, note3 = P0>>1.
REQ-016 Divider counts 0..Pn-1; tick asserted one cycle when count = Pn-1, then count returns to 0.
REQ-017 On tick, addra increments by 1 modulo 2**ADDR_W.
REQ-018 Cycle after tick: pwm_sample <= douta, sample_valid = 1; latency tick->sample_valid exactly 1 cycle.
REQ-019 FSM states: IDLE, HOLD, ARP. IDLE -> HOLD in the cycle after reset deasserts; HOLD -> ARP when arp_en = 1; ARP -> HOLD when arp_en = 0.
REQ-020 HOLD forces note = 0 at the next table wrap; dwell counter held at 0.
REQ-021 ARP: dwell counter counts to NOTE_DWELL-1 then sets step_pending and restarts.
REQ-022 Step applied only on the tick where addra wraps to 0; pending clears then; note and Pn switch together.
REQ-023 Dwell expiry coincident with wrap: step applied on that wrap.
REQ-024 Second dwell expiry while step_pending: no double step; one step per wrap.
REQ-025 arp_en toggling mid-table: state changes immediately; note change deferred to next wrap.
REQ-026 Step order default: 0,1,2,3,0,...
REQ-027 ena = 1 in HOLD and ARP, 0 in IDLE.

Reset
REQ-028 On reset: state IDLE, addra 0, pwm_sample 0, sample_valid 0, note 0, ena 0, divider and dwell counters 0, step_pending 0, P0 latched as DIV_BASE.
REQ-029 Reset mid-period overrides all activity in the same edge; no sample_valid in the cycle after reset.

Configuration
REQ-030 Macro ARP_UPDOWN_EN defined: step order 0,1,2,3,2,1,0,1,... with direction register reset to up; undefined: order per REQ-026, no direction register.

Structure
REQ-031 Package arp_pkg holds the state enum, note-ratio constants (51, 43, shift 6) and note-index type.
REQ-032 Sub-module sample_tick_gen contains the period select/multiply and divider and outputs tick; the FSM, dwell and address logic sit in arp_sequencer.

Verification
REQ-033 Reset, sw_base=0, arp_en=0: ena=1 two cycles after release; sample_valid every 746 cycles; addra 0->1 at first tick; pwm_sample equals BRAM word 0.
REQ-034 sw_base=254, note 0: tick period 1000 cycles; change sw_base mid-table -> period unchanged until addra wraps.
REQ-035 NOTE_DWELL=1000, arp_en=1: note changes only on wraps; periods 746, 594, 501, 373 in sequence; ARP_UPDOWN_EN builds show 373 -> 501 next.
REQ-036 Dwell expiry on the same cycle as wrap: note advances at that wrap, exactly once.
REQ-037 arp_en 1->0 at note 2 mid-table: note remains 2 until wrap, then 0; dwell counter 0.
REQ-038 reset asserted one cycle before a tick: no sample_valid, addra 0, note 0, state IDLE.
